// File: rtl/ahb_sync_sram_slave.sv
// AHB-Lite slave in front of a synchronous single-port SRAM with 1-cycle read latency.
// Define AHB_SRAM_WBUF_EN to add a 1-entry write buffer; without it read-after-write costs one wait.
//
// state  | meaning
// OKAY   | normal response, zero wait
// ERR1   | first ERROR cycle, HREADYOUT low
// ERR2   | second ERROR cycle, HREADYOUT high
// RSTALL | read deferred one cycle behind a dphase write
module ahb_sync_sram_slave #(
    parameter int W_DATA   = 32,
    parameter int W_ADDR   = 32,
    parameter int DEPTH    = 2048,
    localparam int W_SRAM  = $clog2(DEPTH),
    localparam int W_BYTES = W_DATA / 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ahbls_hready,
    output logic               ahbls_hready_resp,
    output logic               ahbls_hresp,
    input  logic               ahbls_hsel,
    input  logic [W_ADDR-1:0]  ahbls_haddr,
    input  logic               ahbls_hwrite,
    input  logic [1:0]         ahbls_htrans,
    input  logic [2:0]         ahbls_hsize,
    input  logic [W_DATA-1:0]  ahbls_hwdata,
    output logic [W_DATA-1:0]  ahbls_hrdata,
    output logic [W_SRAM-1:0]  sram_addr,
    output logic               sram_ce,
    output logic               sram_we,
    output logic [W_BYTES-1:0] sram_wbe,
    output logic [W_DATA-1:0]  sram_wdata,
    input  logic [W_DATA-1:0]  sram_rdata
);

    typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2, ST_RSTALL} state_t;

    state_t             state_q, state_d;
    logic               aph_accept, aph_legal, aph_read, aph_write, aph_err;
    logic [W_SRAM-1:0]  aph_word;
    logic [W_BYTES-1:0] aph_wbe;
    logic               rd_defer;
    logic               dph_write_q;
    logic [W_SRAM-1:0]  dph_addr_q;
    logic [W_BYTES-1:0] dph_wbe_q;

    // Address bits above the SRAM index alias; htrans[0] (SEQ vs NONSEQ) is irrelevant here.
    logic unused;
    assign unused = ^{ahbls_haddr[W_ADDR-1:W_SRAM+2], ahbls_htrans[0]};

    assign aph_word   = ahbls_haddr[W_SRAM+1:2];
    assign aph_accept = ahbls_hready && ahbls_hsel && ahbls_htrans[1];
    assign aph_read   = aph_accept && aph_legal && !ahbls_hwrite;
    assign aph_write  = aph_accept && aph_legal && ahbls_hwrite;
    assign aph_err    = aph_accept && !aph_legal;

    always_comb begin
        aph_legal = 1'b0;
        aph_wbe   = '0;
        case (ahbls_hsize)
            3'd0: begin
                aph_legal = 1'b1;
                aph_wbe   = W_BYTES'(1) << ahbls_haddr[1:0];
            end
            3'd1: begin
                aph_legal = !ahbls_haddr[0];
                aph_wbe   = W_BYTES'(3) << {ahbls_haddr[1], 1'b0};
            end
            3'd2: begin
                aph_legal = (ahbls_haddr[1:0] == 2'b00);
                aph_wbe   = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dph_write_q <= 1'b0;
            dph_addr_q  <= '0;
            dph_wbe_q   <= '0;
        end else if (ahbls_hready) begin
            dph_write_q <= aph_write;
            if (aph_read || aph_write) begin
                dph_addr_q <= aph_word;
                dph_wbe_q  <= aph_wbe;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_OKAY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OKAY, ST_ERR2: begin
                if (aph_err)       state_d = ST_ERR1;
                else if (rd_defer) state_d = ST_RSTALL;
                else               state_d = ST_OKAY;
            end
            ST_ERR1:   state_d = ST_ERR2;
            ST_RSTALL: state_d = ST_OKAY;
            default:   state_d = ST_OKAY;
        endcase
    end

    always_comb begin
        ahbls_hready_resp = !(state_q == ST_ERR1 || state_q == ST_RSTALL);
        ahbls_hresp       = (state_q == ST_ERR1 || state_q == ST_ERR2);
    end

`ifdef AHB_SRAM_WBUF_EN
    logic               wbuf_valid_q;
    logic [W_SRAM-1:0]  wbuf_addr_q;
    logic [W_BYTES-1:0] wbuf_wbe_q;
    logic [W_DATA-1:0]  wbuf_data_q;
    logic               wr_bypass, wbuf_hit;

    assign rd_defer = 1'b0;
    // In back-to-back writes the port is free and the buffer already empty, so the
    // dphase data goes straight to SRAM; this keeps the buffer free for a following read.
    assign wr_bypass = dph_write_q && aph_write && !wbuf_valid_q;
    assign wbuf_hit  = wbuf_valid_q && (wbuf_addr_q == dph_addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            wbuf_valid_q <= 1'b0;
            wbuf_addr_q  <= '0;
            wbuf_wbe_q   <= '0;
            wbuf_data_q  <= '0;
        end else if (dph_write_q && ahbls_hready && !wr_bypass) begin
            wbuf_valid_q <= 1'b1;
            wbuf_addr_q  <= dph_addr_q;
            wbuf_wbe_q   <= dph_wbe_q;
            wbuf_data_q  <= ahbls_hwdata;
        end else if (wbuf_valid_q && !aph_read) begin
            wbuf_valid_q <= 1'b0;
        end
    end

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_wbe   = '0;
        sram_addr  = aph_word;
        sram_wdata = wbuf_data_q;
        if (aph_read) begin
            sram_ce = 1'b1;
        end else if (wr_bypass) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_wbe   = dph_wbe_q;
            sram_addr  = dph_addr_q;
            sram_wdata = ahbls_hwdata;
        end else if (wbuf_valid_q) begin
            sram_ce   = 1'b1;
            sram_we   = 1'b1;
            sram_wbe  = wbuf_wbe_q;
            sram_addr = wbuf_addr_q;
        end
        if (rst) begin
            sram_ce  = 1'b0;
            sram_we  = 1'b0;
            sram_wbe = '0;
        end
    end

    always_comb begin
        ahbls_hrdata = sram_rdata;
        for (int b = 0; b < W_BYTES; b++) begin
            if (wbuf_hit && wbuf_wbe_q[b]) ahbls_hrdata[8*b +: 8] = wbuf_data_q[8*b +: 8];
        end
    end
`else
    assign rd_defer     = aph_read && dph_write_q;
    assign ahbls_hrdata = sram_rdata;

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_wbe   = '0;
        sram_addr  = aph_word;
        sram_wdata = ahbls_hwdata;
        if (dph_write_q) begin
            sram_ce   = 1'b1;
            sram_we   = 1'b1;
            sram_wbe  = dph_wbe_q;
            sram_addr = dph_addr_q;
        end else if (state_q == ST_RSTALL) begin
            sram_ce   = 1'b1;
            sram_addr = dph_addr_q;
        end else if (aph_read) begin
            sram_ce = 1'b1;
        end
        if (rst) begin
            sram_ce  = 1'b0;
            sram_we  = 1'b0;
            sram_wbe = '0;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_sync_sram_slave.sv
// Directed bench for ahb_sync_sram_slave (DEPTH=1024) with a behavioural 1-cycle SRAM.
// Expected wait states follow AHB_SRAM_WBUF_EN when the bench is built with it.
module tb_ahb_sync_sram_slave;

`ifdef AHB_SRAM_WBUF_EN
    localparam int EXP_WAITS = 0;
`else
    localparam int EXP_WAITS = 1;
`endif

    logic        clk, rst;
    logic        hready, hready_resp, hresp;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [9:0]  sram_addr;
    logic        sram_ce, sram_we;
    logic [3:0]  sram_wbe;
    logic [31:0] sram_wdata, sram_rdata;

    logic [31:0] mem [0:1023];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rd;
    int          waits;

    assign hready = hready_resp;

    ahb_sync_sram_slave #(.W_DATA(32), .W_ADDR(32), .DEPTH(1024)) dut (
        .clk               (clk),
        .rst               (rst),
        .ahbls_hready      (hready),
        .ahbls_hready_resp (hready_resp),
        .ahbls_hresp       (hresp),
        .ahbls_hsel        (hsel),
        .ahbls_haddr       (haddr),
        .ahbls_hwrite      (hwrite),
        .ahbls_htrans      (htrans),
        .ahbls_hsize       (hsize),
        .ahbls_hwdata      (hwdata),
        .ahbls_hrdata      (hrdata),
        .sram_addr         (sram_addr),
        .sram_ce           (sram_ce),
        .sram_we           (sram_we),
        .sram_wbe          (sram_wbe),
        .sram_wdata        (sram_wdata),
        .sram_rdata        (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wbe[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_aph(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [31:0] addr, input logic [2:0] size);
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
    endtask

    task automatic set_idle();
        set_aph(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
    endtask

    task automatic wait_ready(output logic [31:0] data, output int nw);
        nw = 0;
        @(negedge clk);
        while (hready_resp !== 1'b1 && nw < 8) begin
            nw++;
            @(posedge clk);
            @(negedge clk);
        end
        data = hrdata;
        tick();
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        set_aph(1'b1, 2'b10, 1'b1, addr, size);
        tick();
        set_idle();
        hwdata = data;
        tick();
        hwdata = 32'h0;
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data, output int nw);
        set_aph(1'b1, 2'b10, 1'b0, addr, 3'd2);
        tick();
        set_idle();
        wait_ready(data, nw);
    endtask

    task automatic ahb_write_read(input logic [31:0] waddr, input logic [2:0] wsize,
                                  input logic [31:0] wdata, input logic [31:0] raddr,
                                  output logic [31:0] data, output int nw);
        set_aph(1'b1, 2'b10, 1'b1, waddr, wsize);
        tick();
        set_aph(1'b1, 2'b10, 1'b0, raddr, 3'd2);
        hwdata = wdata;
        tick();
        set_idle();
        hwdata = 32'h0;
        wait_ready(data, nw);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        sram_rdata = 32'h0;
        rst    = 1'b1;
        hwdata = 32'h0;
        set_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_hready", hready_resp, 1'b1);
        check("reset_hresp", hresp, 1'b0);
        check("reset_ce", sram_ce, 1'b0);
        check("reset_we", sram_we, 1'b0);
        check("reset_wbe", sram_wbe, 4'h0);
        tick();

        ahb_write_read(32'h10, 3'd2, 32'hDEADBEEF, 32'h10, rd, waits);
        check("raw_data", rd, 32'hDEADBEEF);
        check("raw_waits", waits, EXP_WAITS);

        ahb_write(32'h20, 3'd2, 32'h11223344);
        ahb_write(32'h23, 3'd0, 32'hAB000000);
        ahb_write(32'h20, 3'd1, 32'h0000CCDD);
        ahb_read(32'h20, rd, waits);
        check("merge_data", rd, 32'hAB22CCDD);
        check("merge_waits", waits, 0);

        ahb_write_read(32'h21, 3'd0, 32'h00007700, 32'h20, rd, waits);
        check("raw_byte_data", rd, 32'hAB2277DD);
        check("raw_byte_waits", waits, EXP_WAITS);

        set_aph(1'b1, 2'b10, 1'b0, 32'h0, 3'd3);
        @(negedge clk);
        check("err_a_aph_ce", sram_ce, 1'b0);
        tick();
        set_idle();
        @(negedge clk);
        check("err_a_err1_hready", hready_resp, 1'b0);
        check("err_a_err1_hresp", hresp, 1'b1);
        check("err_a_err1_ce", sram_ce, 1'b0);
        tick();
        set_aph(1'b1, 2'b10, 1'b0, 32'h2, 3'd2);
        @(negedge clk);
        check("err_a_err2_hready", hready_resp, 1'b1);
        check("err_a_err2_hresp", hresp, 1'b1);
        check("err_b_aph_ce", sram_ce, 1'b0);
        tick();
        set_idle();
        @(negedge clk);
        check("err_b_err1_hready", hready_resp, 1'b0);
        check("err_b_err1_hresp", hresp, 1'b1);
        check("err_b_err1_ce", sram_ce, 1'b0);
        tick();
        @(negedge clk);
        check("err_b_err2_hready", hready_resp, 1'b1);
        check("err_b_err2_hresp", hresp, 1'b1);
        check("err_b_err2_ce", sram_ce, 1'b0);
        tick();
        @(negedge clk);
        check("err_done_hready", hready_resp, 1'b1);
        check("err_done_hresp", hresp, 1'b0);
        tick();

        ahb_write(32'h1000, 3'd2, 32'h5A5A5A5A);
        ahb_read(32'h0, rd, waits);
        check("alias_data", rd, 32'h5A5A5A5A);

        ahb_write(32'h40, 3'd2, 32'hCAFEF00D);
        tick();
        set_aph(1'b1, 2'b10, 1'b1, 32'h40, 3'd2);
        tick();
        set_idle();
        hwdata = 32'h12345678;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        hwdata = 32'h0;
        @(negedge clk);
        check("rstwr_hready", hready_resp, 1'b1);
        check("rstwr_hresp", hresp, 1'b0);
        check("rstwr_ce", sram_ce, 1'b0);
        tick();
        repeat (2) tick();
        ahb_read(32'h40, rd, waits);
        check("rstwr_data", rd, 32'hCAFEF00D);

        for (int i = 0; i < 10; i++) begin
            if (i < 5) set_aph(1'b0, 2'b10, 1'b0, 32'h10, 3'd2);
            else       set_aph(1'b1, 2'b00, 1'b0, 32'h10, 3'd2);
            @(negedge clk);
            check($sformatf("idle_ce_%0d", i), sram_ce, 1'b0);
            check($sformatf("idle_hready_%0d", i), hready_resp, 1'b1);
            check($sformatf("idle_hresp_%0d", i), hresp, 1'b0);
            tick();
        end
        set_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
